// File: rtl/rr_grant_decoder4_if.sv
// rr_grant_decoder4_if: request/grant bundle between requesters and the round-robin arbiter
interface rr_grant_decoder4_if;
  logic       enable;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       busy;
  modport master (output enable, req, input gnt, gnt_idx, gnt_valid, busy);
  modport slave (input enable, req, output gnt, gnt_idx, gnt_valid, busy);
endinterface

// File: rtl/rr_grant_decoder4.sv
// rr_grant_decoder4: 4-way round-robin arbiter with registered one-hot grant and bounded tenure
module rr_grant_decoder4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input logic              clk,
  input logic              rst,
  rr_grant_decoder4_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);
  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d, idx_q, idx_d, win;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             found, rel;
  // scan from the farthest offset down so the offset nearest ptr wins
  always_comb begin
    win = ptr_q;
    found = 1'b0;
    for (int k = 3; k >= 0; k--)
      if (bus.req[ptr_q + 2'(k)]) begin
        win = ptr_q + 2'(k);
        found = 1'b1;
      end
  end
  assign rel = !bus.enable || !bus.req[idx_q] || (MAX_HOLD != 0 && hold_q == LAST);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    hold_d = '0;
    if (state_q == IDLE) begin
      if (bus.enable && found) begin
        state_d = GRANT;
        idx_d = win;
      end
    end else if (rel) begin
      state_d = IDLE;
      ptr_d = idx_q + 2'd1;
    end else
      hold_d = (MAX_HOLD == 0) ? hold_q : hold_q + CNT_W'(1);
    gnt_d = (state_d == GRANT) ? 4'b0001 << idx_d : 4'b0000;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      idx_q <= '0;
      hold_q <= '0;
      gnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      hold_q <= hold_d;
      gnt_q <= gnt_d;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.gnt_valid = state_q == GRANT;
  assign bus.busy = state_q == GRANT;
endmodule

// File: tb/tb_rr_grant_decoder4.sv
// tb_rr_grant_decoder4: vector table plus rotation and unlimited-hold sequences for rr_grant_decoder4
module tb_rr_grant_decoder4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rr_grant_decoder4_if a ();
  rr_grant_decoder4_if b ();
  rr_grant_decoder4 #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(a.slave));
  rr_grant_decoder4 #(.MAX_HOLD(0)) dut0 (.clk(clk), .rst(rst), .bus(b.slave));
  typedef struct {
    logic       r;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
  } vec_t;
  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
  } exp_t;
  exp_t q[$];
  vec_t tbl[$];
  int checks = 0;
  int errors = 0;
  task automatic compare(input string nm, input logic [3:0] g, input logic [1:0] i, input logic v, input logic bz);
    exp_t e;
    e = q.pop_front();
    checks++;
    if ({g, i, v, bz} !== {e.gnt, e.idx, |e.gnt, |e.gnt}) begin
      errors++;
      $display("FAIL %s: got gnt=%b idx=%0d valid=%b busy=%b, want gnt=%b idx=%0d valid=%b busy=%b",
               nm, g, i, v, bz, e.gnt, e.idx, |e.gnt, |e.gnt);
    end
  endtask
  task automatic step(input string nm, input logic r, input logic en, input logic [3:0] rq,
                      input logic [3:0] eg, input logic [1:0] ei);
    rst = r;
    a.enable = en;
    a.req = rq;
    q.push_back('{eg, ei});
    @(posedge clk);
    #1;
    compare(nm, a.gnt, a.gnt_idx, a.gnt_valid, a.busy);
  endtask
  task automatic add(input logic r, input logic en, input logic [3:0] rq, input logic [3:0] eg,
                     input logic [1:0] ei, input int n);
    for (int k = 0; k < n; k++) tbl.push_back('{r, en, rq, eg, ei});
  endtask
  initial begin
    a.enable = 1'b0;
    a.req = 4'b0000;
    b.enable = 1'b0;
    b.req = 4'b0000;
    add(1, 0, 4'b0000, 4'b0000, 0, 2);
    add(0, 1, 4'b0001, 4'b0001, 0, 3);
    add(0, 1, 4'b0000, 4'b0000, 0, 1);
    add(0, 1, 4'b1001, 4'b1000, 3, 1);
    add(0, 1, 4'b0001, 4'b0000, 3, 1);
    add(0, 1, 4'b1001, 4'b0001, 0, 1);
    add(0, 1, 4'b0000, 4'b0000, 0, 1);
    add(1, 0, 4'b0110, 4'b0000, 0, 1);
    add(0, 0, 4'b0110, 4'b0000, 0, 5);
    add(0, 1, 4'b0110, 4'b0010, 1, 2);
    add(0, 0, 4'b0110, 4'b0000, 1, 1);
    add(0, 1, 4'b0110, 4'b0100, 2, 3);
    add(1, 1, 4'b0101, 4'b0000, 0, 1);
    add(0, 1, 4'b0101, 4'b0001, 0, 4);
    add(0, 1, 4'b0101, 4'b0000, 0, 1);
    add(0, 1, 4'b0101, 4'b0100, 2, 1);
    foreach (tbl[n]) step($sformatf("vec%0d", n), tbl[n].r, tbl[n].en, tbl[n].req, tbl[n].gnt, tbl[n].idx);
    step("rot_rst", 1, 1, 4'b1111, 4'b0000, 0);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) step($sformatf("rot%0d_hold%0d", r, k), 0, 1, 4'b1111, 4'b0001 << r, 2'(r));
      step($sformatf("rot%0d_dead", r), 0, 1, 4'b1111, 4'b0000, 2'(r));
    end
    step("rot_wrap", 0, 1, 4'b1111, 4'b0001, 0);
    rst = 1'b1;
    a.enable = 1'b0;
    q.push_back('{4'b0000, 2'd0});
    @(posedge clk);
    #1;
    compare("nolimit_rst", b.gnt, b.gnt_idx, b.gnt_valid, b.busy);
    rst = 1'b0;
    b.enable = 1'b1;
    b.req = 4'b0001;
    for (int c = 0; c < 300; c++) begin
      q.push_back('{4'b0001, 2'd0});
      @(posedge clk);
      #1;
      compare($sformatf("nolimit%0d", c), b.gnt, b.gnt_idx, b.gnt_valid, b.busy);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_grant_decoder4.md
Name: rr_grant_decoder4

Overview:
- Round-robin arbiter that shares one downstream resource between 4 requesters.
- Encodes the winner as a 2-bit index and drives a registered one-hot grant, the same 2-to-4 decode as the existing decoder, gated by valid.
- Sits in front of any shared 4-way datapath as its sequencer.
- Enforces a maximum grant tenure so no requester can starve the others.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one grant may stay asserted. 0 = no limit. Legal range 0..255.
- CNT_W, 8: width of the internal tenure counter. Must be able to hold MAX_HOLD.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- enable, input, 1: global arbitration enable.
- req, input, 4: request vector. Bit n = requester n.
- gnt, output, 4: registered one-hot grant. 4'b0000 when no grant.
- gnt_idx, output, 2: binary index of current or last grantee.
- gnt_valid, output, 1: high while gnt is non-zero.
- busy, output, 1: high in GRANT state. Identical to gnt_valid.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst high at a rising edge) clears everything on that edge: gnt=0, gnt_idx=0, gnt_valid=0, busy=0, ptr=0, hold_cnt=0, state=IDLE. rst has priority over all other inputs.
- Internal state:
  - 2-bit priority pointer ptr.
  - CNT_W-bit hold_cnt.
  - 2-state FSM: IDLE, GRANT.
- Decode rule: gnt = one-hot(gnt_idx) when gnt_valid, else 4'b0000. gnt is never multi-hot.
- IDLE:
  - If enable=1 and req!=0, search req starting at ptr, then ptr+1, ptr+2, ptr+3 (mod 4). The first set bit wins.
  - Next edge: gnt_idx=winner, gnt_valid=1, hold_cnt=0, state=GRANT.
  - Latency: req sampled at edge N gives gnt visible after edge N+1 (one cycle).
  - Otherwise stay in IDLE with outputs at 0. gnt_idx keeps its last value.
- GRANT, checked each edge in this priority order:
  - a) enable=0 → release.
  - b) req[gnt_idx]=0 → release.
  - c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 → release (forced rotation).
  - d) otherwise hold_cnt++ and stay in GRANT.
- Release:
  - Next edge: gnt_valid=0, gnt=0, ptr=gnt_idx+1 (wraps 3→0), hold_cnt=0, state=IDLE.
  - Always inserts exactly one idle cycle (gnt=0) between two grants, including back-to-back grants to different requesters. This is the dead cycle for downstream mux switching.
- Tenure: with all requests held, each grant lasts exactly MAX_HOLD cycles.
- Requests from non-granted requesters during GRANT are ignored until the next IDLE cycle. The pointer guarantees they are served within 3 tenures.
- A requester that drops and re-raises req in the same cycle as its release is not favoured: ptr has already moved past it.
- req bits are level-sensitive. No latching of pulses: a request must be held until granted.
- gnt_idx, gnt and gnt_valid are all register outputs. There is no combinational path from req or enable to any output.

Test Plan:
1. rst for 2 cycles, then req=4'b0001, enable=1 at edge 1 → gnt=4'b0001, gnt_idx=0, gnt_valid=1 after edge 2. Drop req[0] at edge 4 → gnt=0 after edge 5, ptr=1.
2. MAX_HOLD=4, req=4'b1111 held, enable=1 → gnt sequence repeats: 0001 ×4 cycles, 0000 ×1, 0010 ×4, 0000 ×1, 0100 ×4, 0000 ×1, 1000 ×4, 0000 ×1, then 0001 again (wrap-around).
3. After scenario 1 (ptr=1), req=4'b1001 → grant goes to requester 3 (gnt=4'b1000), not requester 0. After that release, ptr=0 and requester 0 wins next.
4. enable=0 with req=4'b0110 for 5 cycles → gnt stays 0. Raise enable → gnt=4'b0010 one cycle later. Drop enable mid-grant → gnt=0 on the next edge and ptr advances to 2.
5. rst asserted during GRANT (gnt=4'b0100, hold_cnt=2) → after that edge gnt=0, gnt_idx=0, gnt_valid=0, ptr=0. With req=4'b0101 still held → requester 0 wins first.
6. MAX_HOLD=0, req=4'b0001 held for 300 cycles → gnt=4'b0001 continuously. No forced release and no counter wrap side effect.
